// File: rtl/seg_pkg.sv
// Shared symbol codes, 7-segment patterns and FSM state type for the message sequencer.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package seg_pkg;

  // Symbol codes above the decimal digits
  localparam logic [3:0] SYM_BLANK = 4'd10;
  localparam logic [3:0] SYM_V     = 4'd11;
  localparam logic [3:0] SYM_E     = 4'd12;
  localparam logic [3:0] SYM_R     = 4'd13;
  localparam logic [3:0] SYM_DASH  = 4'd14;
  localparam logic [3:0] SYM_DP    = 4'd15;

  // Active-high patterns, bit7 = DP, bits6..0 = g..a
  localparam logic [7:0] PAT_0     = 8'h3F;
  localparam logic [7:0] PAT_1     = 8'h06;
  localparam logic [7:0] PAT_2     = 8'h5B;
  localparam logic [7:0] PAT_3     = 8'h4F;
  localparam logic [7:0] PAT_4     = 8'h66;
  localparam logic [7:0] PAT_5     = 8'h6D;
  localparam logic [7:0] PAT_6     = 8'h7D;
  localparam logic [7:0] PAT_7     = 8'h07;
  localparam logic [7:0] PAT_8     = 8'h7F;
  localparam logic [7:0] PAT_9     = 8'h6F;
  localparam logic [7:0] PAT_BLANK = 8'h00;
  localparam logic [7:0] PAT_V     = 8'h3E;
  localparam logic [7:0] PAT_E     = 8'h79;
  localparam logic [7:0] PAT_R     = 8'h50;
  localparam logic [7:0] PAT_DASH  = 8'h40;
  localparam logic [7:0] PAT_DP    = 8'h80;

  // Index 0 is the blank separator, 1..4 are the message nibbles
  localparam logic [2:0] LAST_IDX = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational 4-bit symbol code to 8-bit 7-segment pattern; SEG_ACTIVE_LOW_EN inverts every pattern.
// Latency: zero cycles, pure combinational.
// Backpressure: none.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [7:0] o_seg
);

  logic [7:0] w_pat;

  // Table lookup of the active-high pattern
  always_comb begin
    w_pat = PAT_BLANK;
    case (i_code)
      4'd0:      w_pat = PAT_0;
      4'd1:      w_pat = PAT_1;
      4'd2:      w_pat = PAT_2;
      4'd3:      w_pat = PAT_3;
      4'd4:      w_pat = PAT_4;
      4'd5:      w_pat = PAT_5;
      4'd6:      w_pat = PAT_6;
      4'd7:      w_pat = PAT_7;
      4'd8:      w_pat = PAT_8;
      4'd9:      w_pat = PAT_9;
      SYM_BLANK: w_pat = PAT_BLANK;
      SYM_V:     w_pat = PAT_V;
      SYM_E:     w_pat = PAT_E;
      SYM_R:     w_pat = PAT_R;
      SYM_DASH:  w_pat = PAT_DASH;
      SYM_DP:    w_pat = PAT_DP;
      default:   w_pat = PAT_BLANK;
    endcase
  end

`ifdef SEG_ACTIVE_LOW_EN
  assign o_seg = ~w_pat;
`else
  assign o_seg = w_pat;
`endif

endmodule

// File: rtl/seg_msg_sequencer.sv
// Round-robin arbiter for two requesters that shows a latched 4-symbol message (blank-led) REPEATS times.
// Latency: grant one edge after req seen in IDLE; seg_out follows the symbol index with no added delay.
// Backpressure: req is a held level; dropping the granted bit aborts, other requests wait for IDLE. Macro: SEG_ACTIVE_LOW_EN.
module seg_msg_sequencer
  import seg_pkg::*;
#(
  parameter int TICKS_PER_SYMBOL = 10000000,
  parameter int REPEATS          = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] msg0,
  input  logic [15:0] msg1,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        done,
  output logic [7:0]  seg_out
);

  localparam int              TW        = $clog2(TICKS_PER_SYMBOL);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS_PER_SYMBOL - 1);
  localparam logic [3:0]      PASS_LAST = 4'(REPEATS - 1);

  state_t        r_state, w_state;
  logic          r_sel,   w_sel;
  logic          r_rr,    w_rr;
  logic [2:0]    r_idx,   w_idx;
  logic [3:0]    r_pass,  w_pass;
  logic [TW-1:0] r_tick,  w_tick;
  logic [15:0]   r_msg,   w_msg;
  logic          r_done,  w_done;

  logic          w_winner;
  logic          w_req_held;
  logic [3:0]    w_sym;

  // On a tie r_rr picks the winner; a lone request always wins
  assign w_winner   = (req == 2'b11) ? r_rr : req[1];
  assign w_req_held = r_sel ? req[1] : req[0];

  // State and counter registers, synchronous reset favours requester 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_rr    <= 1'b0;
      r_idx   <= 3'd0;
      r_pass  <= 4'd0;
      r_tick  <= '0;
      r_msg   <= 16'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_rr    <= w_rr;
      r_idx   <= w_idx;
      r_pass  <= w_pass;
      r_tick  <= w_tick;
      r_msg   <= w_msg;
      r_done  <= w_done;
    end
  end

  // Next-state: grant/latch in IDLE, tick/index/pass stepping or abort in SHOW
  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_rr    = r_rr;
    w_idx   = r_idx;
    w_pass  = r_pass;
    w_tick  = r_tick;
    w_msg   = r_msg;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state = ST_SHOW;
          w_sel   = w_winner;
          w_rr    = ~w_winner;  // pointer moves at grant so aborts advance it too
          w_msg   = w_winner ? msg1 : msg0;
          w_idx   = 3'd0;
          w_pass  = 4'd0;
          w_tick  = '0;
        end
      end
      ST_SHOW: begin
        if (!w_req_held) begin
          w_state = ST_IDLE;
        end else if (r_tick == TICK_LAST) begin
          w_tick = '0;
          if (r_idx == LAST_IDX) begin
            w_idx = 3'd0;
            if (r_pass == PASS_LAST) begin
              w_state = ST_IDLE;
              w_done  = 1'b1;
            end else begin
              w_pass = r_pass + 4'd1;
            end
          end else begin
            w_idx = r_idx + 3'd1;
          end
        end else begin
          w_tick = r_tick + 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // Pick the symbol for the current index; dash whenever idle
  always_comb begin
    w_sym = SYM_DASH;
    if (r_state == ST_SHOW) begin
      case (r_idx)
        3'd1:    w_sym = r_msg[15:12];
        3'd2:    w_sym = r_msg[11:8];
        3'd3:    w_sym = r_msg[7:4];
        3'd4:    w_sym = r_msg[3:0];
        default: w_sym = SYM_BLANK;
      endcase
    end
  end

  seg_decode u_decode (
    .i_code (w_sym),
    .o_seg  (seg_out)
  );

  assign busy  = (r_state == ST_SHOW);
  assign grant = busy ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
  assign done  = r_done;

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Directed bench: two sequencer instances (REPEATS=1 and REPEATS=2, TICKS_PER_SYMBOL=4).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: req levels driven directly by the stimulus sequence.
module tb_seg_msg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_a, req_b;
  logic [15:0] m0a, m1a, m0b, m1b;
  logic [1:0]  grant_a, grant_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [7:0]  seg_a, seg_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] e_single [5] = '{8'h00, 8'h06, 8'h5B, 8'h4F, 8'h66};
  logic [7:0] e_tie    [5] = '{8'h00, 8'h3E, 8'h79, 8'h50, 8'h00};
  logic [7:0] e_rep    [5] = '{8'h00, 8'h6F, 8'h6F, 8'h6F, 8'h3F};

  seg_msg_sequencer #(.TICKS_PER_SYMBOL(4), .REPEATS(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .msg0(m0a), .msg1(m1a),
    .grant(grant_a), .busy(busy_a), .done(done_a), .seg_out(seg_a)
  );

  seg_msg_sequencer #(.TICKS_PER_SYMBOL(4), .REPEATS(2)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .msg0(m0b), .msg1(m1b),
    .grant(grant_b), .busy(busy_b), .done(done_b), .seg_out(seg_b)
  );

  function automatic logic [7:0] pol(input logic [7:0] p);
`ifdef SEG_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_a = 2'b00; req_b = 2'b00;
    m0a = 16'h0; m1a = 16'h0; m0b = 16'h0; m1b = 16'h0;

    // Reset state
    repeat (3) tick();
    chk("rst_seg_a",   seg_a,          pol(8'h40));
    chk("rst_grant_a", 8'(grant_a),    8'h00);
    chk("rst_busy_a",  8'(busy_a),     8'h00);
    chk("rst_done_a",  8'(done_a),     8'h00);
    chk("rst_seg_b",   seg_b,          pol(8'h40));
    chk("rst_grant_b", 8'(grant_b),    8'h00);
    rst = 1'b0;

    // Single request, msg0 = 0x1234
    m0a = 16'h1234; req_a = 2'b01;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("single_seg",   seg_a,       pol(e_single[k/4]));
      chk("single_busy",  8'(busy_a),  8'h01);
      chk("single_grant", 8'(grant_a), 8'h01);
      chk("single_done",  8'(done_a),  8'h00);
    end
    tick();
    chk("single_donepulse", 8'(done_a),  8'h01);
    chk("single_end_grant", 8'(grant_a), 8'h00);
    chk("single_end_busy",  8'(busy_a),  8'h00);
    chk("single_end_seg",   seg_a,       pol(8'h40));
    req_a = 2'b00;
    tick();
    chk("single_after_done", 8'(done_a), 8'h00);
    chk("single_after_busy", 8'(busy_a), 8'h00);
    chk("single_after_seg",  seg_a,      pol(8'h40));

    // Tie from reset: requester 0 first, then requester 1 from the done cycle
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    m1a = 16'hBCDA; req_a = 2'b11;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("tie0_grant", 8'(grant_a), 8'h01);
      chk("tie0_seg",   seg_a,       pol(e_single[k/4]));
    end
    tick();
    chk("tie0_done",  8'(done_a),  8'h01);
    chk("tie0_grant_idle", 8'(grant_a), 8'h00);
    tick();
    chk("tie1_grant_first", 8'(grant_a), 8'h02);
    chk("tie1_seg_first",   seg_a,       pol(e_tie[0]));
    req_a = 2'b10;
    for (int k = 1; k < 20; k++) begin
      tick();
      chk("tie1_grant", 8'(grant_a), 8'h02);
      chk("tie1_seg",   seg_a,       pol(e_tie[k/4]));
    end
    tick();
    chk("tie1_done", 8'(done_a), 8'h01);
    req_a = 2'b00;
    tick();

    // Abort: drop req[0] at the 7th grant cycle; digit 8 visible in index 1
    m0a = 16'h8123; req_a = 2'b01;
    repeat (7) tick();
    chk("abort_pre_seg",   seg_a,       pol(8'h7F));
    chk("abort_pre_grant", 8'(grant_a), 8'h01);
    req_a = 2'b00;
    tick();
    chk("abort_grant", 8'(grant_a), 8'h00);
    chk("abort_seg",   seg_a,       pol(8'h40));
    chk("abort_done",  8'(done_a),  8'h00);
    chk("abort_busy",  8'(busy_a),  8'h00);
    tick();
    chk("abort_done_late", 8'(done_a), 8'h00);
    req_a = 2'b11;
    tick();
    chk("abort_tie_grant", 8'(grant_a), 8'h02);
    req_a = 2'b00;
    tick();
    chk("abort2_grant", 8'(grant_a), 8'h00);
    chk("abort2_done",  8'(done_a),  8'h00);

    // REPEATS=2 instance, msg1 = 0x9990 changed mid-grant
    m1b = 16'h9990; req_b = 2'b10;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 10) m1b = 16'h1234;
      chk("rep_seg",   seg_b,       pol(e_rep[(k % 20) / 4]));
      chk("rep_busy",  8'(busy_b),  8'h01);
      chk("rep_grant", 8'(grant_b), 8'h02);
      chk("rep_done",  8'(done_b),  8'h00);
    end
    tick();
    chk("rep_donepulse", 8'(done_b),  8'h01);
    chk("rep_end_busy",  8'(busy_b),  8'h00);
    chk("rep_end_grant", 8'(grant_b), 8'h00);
    chk("rep_end_seg",   seg_b,       pol(8'h40));
    req_b = 2'b00;
    tick();
    chk("rep_after_done", 8'(done_b), 8'h00);
    chk("rep_after_busy", 8'(busy_b), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_msg_sequencer.md
SEG_MSG_SEQUENCER -- requirements
Module: seg_msg_sequencer

Interface
REQ-001 Parameter TICKS_PER_SYMBOL, default 10000000, clock cycles each symbol is held on the display; legal range 2 or more.
REQ-002 Parameter REPEATS, default 2, number of full message passes per grant; legal range 1 to 15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req  input  2  per-requester display request, level, held high until grant completes or is abandoned.
REQ-006 msg0  input  16  requester 0 message, four 4-bit symbol codes, [15:12] shown first.
REQ-007 msg1  input  16  requester 1 message, same layout.
REQ-008 grant  output  2  one-hot, marks the requester owning the display; all-zero when idle.
REQ-009 busy  output  1  high while a message is being sequenced.
REQ-010 done  output  1  one-cycle pulse on normal completion of a grant.
REQ-011 seg_out  output  8  7-segment pattern, bit7 = DP, bits6..0 = g..a.

Function
REQ-012 Symbol codes: 0-9 are digits; 10 is blank (0x00); 11 is V (0x3E); 12 is E (0x79); 13 is R (0x50); 14 is dash (0x40); 15 is DP only (0x80).
REQ-013 Digit patterns are 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07, 0x7F, 0x6F.
REQ-014 States: IDLE, SHOW; SHOW is tracked by symbol index 0-4 (0 = blank separator, 1-4 = message nibbles), pass counter, and tick counter.
REQ-015 In IDLE, seg_out shows dash, grant = 0, busy = 0.
REQ-016 In IDLE with any req bit high, the block grants one requester on the next edge, latches that requester's msg, and enters SHOW with index 0, pass 0, tick 0.
REQ-017 Arbitration is round-robin: both requesting after reset means requester 0 wins; after serving requester g, the other requester wins on a tie.
REQ-018 req is sampled only in IDLE; a request arriving during SHOW waits.
REQ-019 Latched message is immune to msg changes after grant.
REQ-020 Each index is held exactly TICKS_PER_SYMBOL cycles; tick wraps to 0 and index advances 0→1→2→3→4→0 (pass+1).
REQ-021 seg_out is the decode of the current index symbol in the same cycle the index is valid (no added latency).
REQ-022 Normal grant duration is exactly 5 × REPEATS × TICKS_PER_SYMBOL cycles with busy high.
REQ-023 At the final tick of index 4 of pass REPEATS-1, the next cycle is IDLE with done = 1 for that one cycle and grant = 0.
REQ-024 A new grant may be issued from the done cycle, i.e. SHOW is re-entered on the following edge.
REQ-025 Abort: if the granted req bit is low in any SHOW cycle, the next cycle is IDLE, done stays 0, and the round-robin pointer still advances.
REQ-026 The tick counter width is the minimum holding TICKS_PER_SYMBOL-1; it has no overflow beyond wrap.

Reset
REQ-027 While rst is high: state IDLE, grant 0, busy 0, done 0, seg_out 0x40, round-robin pointer favours requester 0, counters 0.
REQ-028 Reset asserted mid-SHOW abandons the message with no done pulse.

Configuration
REQ-029 Macro SEG_ACTIVE_LOW_EN: when defined, seg_out is the bitwise inverse of every pattern above, including the reset value 0xBF.
REQ-030 When the macro is undefined, seg_out is active-high as specified.

Structure
REQ-031 Shared package seg_pkg holds the symbol code constants, the state typedef, and the 8-bit pattern constants.
REQ-032 Sub-module seg_decode (combinational, 4-bit code to 8-bit pattern) is instantiated once; the polarity inversion lives in seg_decode.

Verification (TICKS_PER_SYMBOL=4, REPEATS=1 unless noted)
REQ-033 Reset: rst high 3 cycles -> seg_out 0x40, grant 00, busy 0, done 0.
REQ-034 Single request: req=01, msg0=0x1234 -> seg_out sequence 0x00, 0x06, 0x5B, 0x4F, 0x66, each 4 cycles; busy 20 cycles; done pulse once; then 0x40.
REQ-035 Tie: req=11 from reset, msg1=0xBCDA -> grant 01 first; grant 10 second, starting the cycle after done; second sequence 0x00, 0x3E, 0x79, 0x50, 0x00.
REQ-036 Abort: req=01, drop req[0] at cycle 7 of grant -> next cycle grant 00, seg_out 0x40, no done; later tie goes to requester 1.
REQ-037 REPEATS=2, req=10, msg1=0x9990 -> 40 busy cycles, two passes, single done; msg1 changed mid-grant has no effect.
REQ-038 SEG_ACTIVE_LOW_EN defined -> reset seg_out 0xBF, digit 8 shown as 0x80.
